// File: rtl/mux_sel_scanner_pkg.sv
// Shared week4 definitions for the mux select scanner: state encoding,
// the default select width and the dwell-counter sizing helper.
package mux_sel_scanner_pkg;

   localparam int SEL_W_DEFAULT = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } scan_state_t;

   // A dwell of 1 or 2 cycles still needs a one-bit counter.
   function automatic int div_cnt_width(input int clk_div);
      return (clk_div <= 2) ? 1 : $clog2(clk_div);
   endfunction

endpackage

// File: rtl/mux_sel_scanner_dwell_divider.sv
// Dwell counter for the select scanner: counts 0..CLK_DIV-1 and raises a
// registered terminal-count pulse during the final dwell cycle.
module dwell_divider
   import mux_sel_scanner_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   input  logic arm,
   output logic tc
);

   localparam int CNT_W = div_cnt_width(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt_q;
      if (clear) begin
         cnt_next = '0;
      end else if (enable) begin
         cnt_next = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // The pulse is decided from the count the next cycle will hold, so it is
   // a flop yet lines up exactly with the terminal dwell cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         tc    <= 1'b0;
      end else begin
         cnt_q <= cnt_next;
         tc    <= arm && (cnt_next == CNT_MAX);
      end
   end

endmodule

// File: rtl/mux_sel_scanner.sv
// Select sequencer for the week4 16-to-1 mux: steps sel across a latched
// range at a fixed dwell, strobing sample_en on the last cycle of each value.
module mux_sel_scanner
   import mux_sel_scanner_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int SEL_W   = SEL_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             mode,
   input  logic [SEL_W-1:0] first_sel,
   input  logic [SEL_W-1:0] last_sel,
   output logic [SEL_W-1:0] sel,
   output logic             sample_en,
   output logic             busy,
   output logic             wrap,
   output logic             done
);

   scan_state_t      state_q;
   scan_state_t      state_next;
   logic [SEL_W-1:0] sel_next;
   logic [SEL_W-1:0] first_q;
   logic [SEL_W-1:0] first_next;
   logic [SEL_W-1:0] last_q;
   logic [SEL_W-1:0] last_next;
   logic             mode_q;
   logic             mode_next;
   logic             wrap_next;
   logic             div_clear;
   logic             div_enable;

   dwell_divider #(
      .CLK_DIV(CLK_DIV)
   ) u_divider (
      .clk    (clk),
      .rst    (rst),
      .clear  (div_clear),
      .enable (div_enable),
      .arm    (state_next == ST_RUN),
      .tc     (sample_en)
   );

   // The strobe cycle doubles as the advance point; a stop in that same
   // cycle wins, so the strobe is still seen but sel does not move.
   always_comb begin
      state_next = state_q;
      sel_next   = sel;
      first_next = first_q;
      last_next  = last_q;
      mode_next  = mode_q;
      wrap_next  = 1'b0;
      div_clear  = 1'b0;
      div_enable = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               first_next = first_sel;
               last_next  = last_sel;
               mode_next  = mode;
               sel_next   = first_sel;
               div_clear  = 1'b1;
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_next = ST_DONE;
            end else if (sample_en) begin
               div_clear = 1'b1;
               if (sel != last_q) begin
                  sel_next = sel + SEL_W'(1);
               end else if (mode_q) begin
                  sel_next  = first_q;
                  wrap_next = 1'b1;
               end else begin
                  state_next = ST_DONE;
               end
            end else begin
               div_enable = 1'b1;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel     <= '0;
         first_q <= '0;
         last_q  <= '0;
         mode_q  <= 1'b0;
         busy    <= 1'b0;
         wrap    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_next;
         sel     <= sel_next;
         first_q <= first_next;
         last_q  <= last_next;
         mode_q  <= mode_next;
         busy    <= (state_next == ST_RUN);
         wrap    <= wrap_next;
         done    <= (state_next == ST_DONE);
      end
   end

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Directed bench for mux_sel_scanner: one instance with a 4-cycle dwell and
// one with a 1-cycle dwell, checked at each falling edge.
module tb_mux_sel_scanner;

   logic       clk;
   logic       rst;
   logic       start4;
   logic       start1;
   logic       stop;
   logic       mode;
   logic [3:0] first_sel;
   logic [3:0] last_sel;
   logic [3:0] sel4;
   logic [3:0] sel1;
   logic       se4;
   logic       se1;
   logic       busy4;
   logic       busy1;
   logic       wrap4;
   logic       wrap1;
   logic       done4;
   logic       done1;

   int checks = 0;
   int errors = 0;

   logic [3:0] seq2 [4];

   mux_sel_scanner #(.CLK_DIV(4), .SEL_W(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .start     (start4),
      .stop      (stop),
      .mode      (mode),
      .first_sel (first_sel),
      .last_sel  (last_sel),
      .sel       (sel4),
      .sample_en (se4),
      .busy      (busy4),
      .wrap      (wrap4),
      .done      (done4)
   );

   mux_sel_scanner #(.CLK_DIV(1), .SEL_W(4)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .start     (start1),
      .stop      (stop),
      .mode      (mode),
      .first_sel (first_sel),
      .last_sel  (last_sel),
      .sel       (sel1),
      .sample_en (se1),
      .busy      (busy1),
      .wrap      (wrap1),
      .done      (done1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic s4, input logic s1, input logic sp,
                                input logic md, input logic [3:0] f,
                                input logic [3:0] l);
      start4    = s4;
      start1    = s1;
      stop      = sp;
      mode      = md;
      first_sel = f;
      last_sel  = l;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkState(input bit use1, input string tag,
                             input logic [3:0] es, input logic ese,
                             input logic eb, input logic ew, input logic ed);
      if (use1) begin
         checkOutput({tag, ".sel"},       32'(sel1),  32'(es));
         checkOutput({tag, ".sample_en"}, 32'(se1),   32'(ese));
         checkOutput({tag, ".busy"},      32'(busy1), 32'(eb));
         checkOutput({tag, ".wrap"},      32'(wrap1), 32'(ew));
         checkOutput({tag, ".done"},      32'(done1), 32'(ed));
      end else begin
         checkOutput({tag, ".sel"},       32'(sel4),  32'(es));
         checkOutput({tag, ".sample_en"}, 32'(se4),   32'(ese));
         checkOutput({tag, ".busy"},      32'(busy4), 32'(eb));
         checkOutput({tag, ".wrap"},      32'(wrap4), 32'(ew));
         checkOutput({tag, ".done"},      32'(done4), 32'(ed));
      end
   endtask

   initial begin
      seq2[0] = 4'd14;
      seq2[1] = 4'd15;
      seq2[2] = 4'd0;
      seq2[3] = 4'd1;

      // Reset values while rst is held
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 4'd0, 4'd0);
      tick();
      tick();
      checkState(0, "reset4", 4'd0, 0, 0, 0, 0);
      checkState(1, "reset1", 4'd0, 0, 0, 0, 0);
      rst = 1'b0;
      tick();

      // Full single pass 0..15, four cycles per value
      $display("[TB] full range single pass");
      applyStimulus(1, 0, 0, 0, 4'd0, 4'd15);
      tick();
      applyStimulus(0, 0, 0, 0, 4'd0, 4'd15);
      for (int c = 0; c < 64; c++) begin
         checkState(0, "t1_run", 4'(c / 4), (c % 4) == 3, 1, 0, 0);
         tick();
      end
      checkState(0, "t1_done", 4'd15, 0, 0, 0, 1);
      tick();
      checkState(0, "t1_idle", 4'd15, 0, 0, 0, 0);

      // Range passing through 15 -> 0
      $display("[TB] wrapping range 14..1");
      applyStimulus(1, 0, 0, 0, 4'd14, 4'd1);
      tick();
      applyStimulus(0, 0, 0, 0, 4'd14, 4'd1);
      for (int c = 0; c < 16; c++) begin
         checkState(0, "t2_run", seq2[c / 4], (c % 4) == 3, 1, 0, 0);
         tick();
      end
      checkState(0, "t2_done", 4'd1, 0, 0, 0, 1);
      tick();
      checkState(0, "t2_idle", 4'd1, 0, 0, 0, 0);
      tick();
      checkState(0, "t2_hold", 4'd1, 0, 0, 0, 0);

      // Continuous 3..5 for three passes, then stop
      $display("[TB] continuous 3..5 with stop");
      applyStimulus(1, 0, 0, 1, 4'd3, 4'd5);
      tick();
      applyStimulus(0, 0, 0, 1, 4'd3, 4'd5);
      for (int c = 0; c < 39; c++) begin
         checkState(0, "t3_run", 4'(3 + (c / 4) % 3), (c % 4) == 3, 1,
                    (c % 4 == 0) && ((c / 4) % 3 == 0) && (c > 0), 0);
         if (c < 38) tick();
      end
      applyStimulus(0, 0, 1, 1, 4'd3, 4'd5);
      tick();
      checkState(0, "t3_stop_done", 4'd3, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1, 4'd3, 4'd5);
      tick();
      checkState(0, "t3_idle", 4'd3, 0, 0, 0, 0);

      // One-cycle dwell, single-entry continuous range, ignored start/inputs
      $display("[TB] one-cycle dwell, first == last == 7");
      applyStimulus(0, 1, 0, 1, 4'd7, 4'd7);
      tick();
      applyStimulus(0, 0, 0, 1, 4'd7, 4'd7);
      checkState(1, "t4_first", 4'd7, 1, 1, 0, 0);
      tick();
      checkState(1, "t4_wrap", 4'd7, 1, 1, 1, 0);
      applyStimulus(0, 1, 0, 0, 4'd2, 4'd9);
      tick();
      checkState(1, "t4_ignore", 4'd7, 1, 1, 1, 0);
      applyStimulus(0, 0, 0, 0, 4'd2, 4'd9);
      for (int c = 0; c < 3; c++) begin
         tick();
         checkState(1, "t4_hold", 4'd7, 1, 1, 1, 0);
      end
      applyStimulus(0, 0, 1, 0, 4'd2, 4'd9);
      tick();
      checkState(1, "t4_stop_done", 4'd7, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 4'd2, 4'd9);
      tick();
      checkState(1, "t4_idle", 4'd7, 0, 0, 0, 0);

      // Asynchronous reset mid-scan, then a clean restart
      $display("[TB] async reset mid-scan");
      applyStimulus(1, 0, 0, 0, 4'd5, 4'd12);
      tick();
      applyStimulus(0, 0, 0, 0, 4'd5, 4'd12);
      for (int c = 0; c < 16; c++) tick();
      checkState(0, "t5_before", 4'd9, 0, 1, 0, 0);
      #2 rst = 1'b1;
      #1 checkState(0, "t5_async", 4'd0, 0, 0, 0, 0);
      #1 rst = 1'b0;
      tick();
      checkState(0, "t5_after", 4'd0, 0, 0, 0, 0);
      tick();
      checkState(0, "t5_nodone", 4'd0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 4'd0, 4'd1);
      tick();
      applyStimulus(0, 0, 0, 0, 4'd0, 4'd1);
      for (int c = 0; c < 8; c++) begin
         checkState(0, "t5_restart", 4'(c / 4), (c % 4) == 3, 1, 0, 0);
         tick();
      end
      checkState(0, "t5_done", 4'd1, 0, 0, 0, 1);
      tick();

      // Stop landing on the strobe cycle of sel=4
      $display("[TB] stop coinciding with strobe");
      applyStimulus(1, 0, 0, 0, 4'd2, 4'd8);
      tick();
      applyStimulus(0, 0, 0, 0, 4'd2, 4'd8);
      for (int c = 0; c < 11; c++) begin
         checkState(0, "t6_run", 4'(2 + c / 4), (c % 4) == 3, 1, 0, 0);
         tick();
      end
      checkState(0, "t6_strobe", 4'd4, 1, 1, 0, 0);
      applyStimulus(0, 0, 1, 0, 4'd2, 4'd8);
      tick();
      checkState(0, "t6_done", 4'd4, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 4'd2, 4'd8);
      tick();
      checkState(0, "t6_idle", 4'd4, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_sel_scanner.md
Name: mux_sel_scanner

Overview:
- Upstream select sequencer for the 16-to-1 bit multiplexer in the week4 datapath.
- Steps the 4-bit select across a programmable range [first_sel..last_sel] at a fixed dwell rate.
- Issues a sample strobe while each select value is stable, so downstream logic can capture the multiplexed bit Y.
- Supports single-pass and continuous (wrapping) scan modes, plus a start/busy/done handshake.

Parameters:
- CLK_DIV, 4, clock cycles spent on each select value (dwell); legal range 1..256.
- SEL_W, 4, select width; the select space is 2^SEL_W entries (16).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  single-cycle request to begin a scan; sampled only in IDLE.
- stop  input  1  abort request; honoured only in RUN.
- mode  input  1  0 = single pass, 1 = continuous.
- first_sel  input  SEL_W  first select index; captured on the accepted start.
- last_sel  input  SEL_W  final select index; captured on the accepted start.
- sel  output  SEL_W  select value driven to the mux.
- sample_en  output  1  high for exactly one cycle: the last dwell cycle of each select value.
- busy  output  1  high while in RUN.
- wrap  output  1  one-cycle pulse when a continuous scan reloads first_sel.
- done  output  1  one-cycle pulse when a scan ends (completed or aborted).

Behaviour:
- Reset (async, rst=1): state=IDLE, sel=0, div_cnt=0, sample_en=0, busy=0, wrap=0, done=0; latched first/last/mode cleared to 0.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - sel holds its previous value.
  - On start=1: latch first_sel, last_sel and mode; sel<=first_sel; div_cnt<=0; go to RUN.
  - busy rises on the cycle after start.
- RUN:
  - busy=1; div_cnt increments 0..CLK_DIV-1.
  - sample_en=1 exactly during the cycle with div_cnt==CLK_DIV-1. sel is therefore stable for CLK_DIV-1 cycles before the strobe.
  - At the end of that strobe cycle:
    - If sel != last_latched: sel<=sel+1, modulo 2^SEL_W (15 wraps to 0); div_cnt<=0.
    - If sel == last_latched and mode=1: sel<=first_latched; wrap pulses on the next cycle; div_cnt<=0.
    - If sel == last_latched and mode=0: go to DONE; sel holds last_latched.
  - first_sel > last_sel is legal: the scan passes through 15 to 0. Example: 14,15,0,1.
  - first_sel == last_sel: a single-entry scan, with one sample_en per pass.
  - CLK_DIV=1: sample_en is high every RUN cycle and sel advances every cycle.
- stop in RUN:
  - Go to DONE on the next edge; sample_en is forced 0 in that cycle; sel holds.
  - If stop coincides with a sample cycle, that sample_en still asserts (registered earlier). The increment is suppressed.
- DONE: done=1 and busy=0 for one cycle, then return to IDLE.
- Ignored inputs:
  - start while in RUN or DONE; stop while in IDLE or DONE.
  - start and stop in the same IDLE cycle: start wins and stop is ignored.
- Input changes during a scan: changes to first_sel, last_sel or mode have no effect until the next accepted start.
- rst mid-scan: immediate return to reset values; no done pulse.
- Scan length: single pass visits N = ((last-first) mod 16)+1 values. A scan takes N*CLK_DIV RUN cycles plus 1 DONE cycle.

Decomposition:
- Shared package (week4 common):
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - SEL_W default;
  - the divider-counter width function (clog2 of CLK_DIV, minimum 1).
- Natural sub-module: dwell_divider.
  - A counter with clear and enable, producing a terminal-count pulse.
  - The FSM consumes that pulse as sample_en and as the advance condition.
- Top level: instantiates dwell_divider plus the select register and FSM. It is connected to the mux's sel port in the integration top.

Test Plan:
1. CLK_DIV=4, first=0, last=15, mode=0, start pulse → sel steps 0..15, each held 4 cycles; 16 sample_en pulses spaced 4 apart; done 1 cycle after sel=15's strobe; busy high for 64 cycles.
2. first=14, last=1, mode=0 → sel sequence 14,15,0,1; 4 samples; done pulses; sel holds 1 in IDLE.
3. first=3, last=5, mode=1, run 3 passes → sequence 3,4,5,3,4,5,...; wrap pulses after each sel=5 strobe; no done; stop then gives done within 2 cycles with sel frozen.
4. CLK_DIV=1, first=last=7 → sample_en high every RUN cycle; sel constant 7. Also: start asserted during RUN is ignored, and latched range changes mid-scan have no effect.
5. Assert rst asynchronously mid-scan (sel=9) → sel=0, busy=0, sample_en=0 without a clock edge; no done pulse. A subsequent start works normally.
6. stop coinciding with the strobe at sel=4 (first=2, last=8) → sample_en still seen for 4; sel stays 4, no advance; DONE next, then IDLE.
